// File: rtl/alu_pkg.sv
// Shared definitions for the Y86 execute-stage ALU: function-select encodings,
// the datapath width and the full-adder cell used by the ripple-carry adder.
package alu_pkg;

    localparam int WORD_W = 64;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_XOR = 2'b10;
    localparam logic [1:0] ALU_AND = 2'b11;

    // One full-adder cell: returns {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic cin);
        logic s;
        logic c;
        s = a ^ b ^ cin;
        c = (a & b) | (cin & (a ^ b));
        return {c, s};
    endfunction

endpackage

// File: rtl/alu_adder_64.sv
// 64-bit ripple-carry adder built from a chain of full-adder cells.
module adder_64
    import alu_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              cin,
    output logic [WORD_W-1:0] sum,
    output logic              cout
);

    logic [1:0] cell_s;
    logic       carry_s;

    // Walk the carry from bit 0 upward through each full-adder cell.
    always_comb begin
        carry_s = cin;
        cell_s  = 2'b00;
        sum     = {WORD_W{1'b0}};
        for (int i = 0; i < WORD_W; i++) begin
            cell_s  = full_add(a[i], b[i], carry_s);
            sum[i]  = cell_s[0];
            carry_s = cell_s[1];
        end
        cout = carry_s;
    end

endmodule

// File: rtl/alu.sv
// Y86 SEQ execute-stage ALU: combinational add/sub/xor/and with signed overflow,
// plus the registered ZF/SF/OF condition codes.
module alu
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        S0,
    input  logic [WORD_W-1:0] X,
    input  logic [WORD_W-1:0] Y,
    input  logic              cc_en,
    output logic [WORD_W-1:0] Z,
    output logic              ovf,
    output logic              zf,
    output logic              sf,
    output logic              of
);

    logic [WORD_W-1:0] add_b_s;
    logic [WORD_W-1:0] add_sum_s;
    logic              unused_cout_s;
    logic              zf_d;
    logic              sf_d;
    logic              of_d;
    logic              zf_q;
    logic              sf_q;
    logic              of_q;

    // Subtraction reuses the adder as X + ~Y + 1; S0[0] distinguishes sub from add.
    assign add_b_s = S0[0] ? ~Y : Y;

    adder_64 u_adder (
        .a    (X),
        .b    (add_b_s),
        .cin  (S0[0]),
        .sum  (add_sum_s),
        .cout (unused_cout_s)
    );

    // Result mux and signed-overflow detection for the selected function.
    always_comb begin
        Z   = {WORD_W{1'b0}};
        ovf = 1'b0;
        case (S0)
            ALU_ADD: begin
                Z   = add_sum_s;
                ovf = (X[WORD_W-1] == Y[WORD_W-1]) & (add_sum_s[WORD_W-1] != X[WORD_W-1]);
            end
            ALU_SUB: begin
                Z   = add_sum_s;
                ovf = (X[WORD_W-1] != Y[WORD_W-1]) & (add_sum_s[WORD_W-1] != X[WORD_W-1]);
            end
            ALU_XOR: begin
                Z   = X ^ Y;
                ovf = 1'b0;
            end
            ALU_AND: begin
                Z   = X & Y;
                ovf = 1'b0;
            end
            default: begin
                Z   = {WORD_W{1'b0}};
                ovf = 1'b0;
            end
        endcase
    end

    // Next condition codes: load from this cycle's result when enabled, else hold.
    always_comb begin
        if (cc_en) begin
            zf_d = (Z == {WORD_W{1'b0}});
            sf_d = Z[WORD_W-1];
            of_d = ovf;
        end else begin
            zf_d = zf_q;
            sf_d = sf_q;
            of_d = of_q;
        end
    end

    // Condition-code register, cleared asynchronously by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zf_q <= 1'b0;
            sf_q <= 1'b0;
            of_q <= 1'b0;
        end else begin
            zf_q <= zf_d;
            sf_q <= sf_d;
            of_q <= of_d;
        end
    end

    assign zf = zf_q;
    assign sf = sf_q;
    assign of = of_q;

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu: datapath vectors, condition-code
// load/hold, and asynchronous reset behaviour.
module tb_alu;

    logic        clk;
    logic        rst_n;
    logic [1:0]  S0;
    logic [63:0] X;
    logic [63:0] Y;
    logic        cc_en;
    logic [63:0] Z;
    logic        ovf;
    logic        zf;
    logic        sf;
    logic        of;

    int checks;
    int failures;

    alu dut (
        .clk   (clk),
        .rst_n (rst_n),
        .S0    (S0),
        .X     (X),
        .Y     (Y),
        .cc_en (cc_en),
        .Z     (Z),
        .ovf   (ovf),
        .zf    (zf),
        .sf    (sf),
        .of    (of)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b1;
        cc_en = 1'b1;
        S0 = 2'b00; X = 64'h7FFF_FFFF_FFFF_FFFF; Y = 64'd1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({zf, sf, of} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags got=%b want=000", {zf, sf, of});
        end
        // A clock edge while reset is held must not load the flags.
        @(posedge clk); #1;
        checks++;
        if ({zf, sf, of} !== 3'b000) begin
            failures++;
            $display("FAIL reset_wins_edge got=%b want=000", {zf, sf, of});
        end
        @(negedge clk);
        rst_n = 1'b1;
        cc_en = 1'b0;
    endtask

    task automatic test_add();
        @(negedge clk);
        S0 = 2'b00; X = 64'd5; Y = 64'd7;
        #1;
        checks++;
        if (Z !== 64'd12 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL add_small got Z=%h ovf=%b want Z=%h ovf=0", Z, ovf, 64'd12);
        end
        S0 = 2'b00; X = 64'h7FFF_FFFF_FFFF_FFFF; Y = 64'd1;
        #1;
        checks++;
        if (Z !== 64'h8000_0000_0000_0000 || ovf !== 1'b1) begin
            failures++;
            $display("FAIL add_ovf got Z=%h ovf=%b want Z=8000000000000000 ovf=1", Z, ovf);
        end
        S0 = 2'b00; X = 64'hFFFF_FFFF_FFFF_FFFF; Y = 64'd1;
        #1;
        checks++;
        if (Z !== 64'd0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL add_carry_wrap got Z=%h ovf=%b want Z=0 ovf=0", Z, ovf);
        end
    endtask

    task automatic test_sub();
        @(negedge clk);
        S0 = 2'b01; X = 64'd3; Y = 64'd10;
        #1;
        checks++;
        if (Z !== 64'hFFFF_FFFF_FFFF_FFF9 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL sub_neg got Z=%h ovf=%b want Z=fffffffffffffff9 ovf=0", Z, ovf);
        end
        S0 = 2'b01; X = 64'h8000_0000_0000_0000; Y = 64'd1;
        #1;
        checks++;
        if (Z !== 64'h7FFF_FFFF_FFFF_FFFF || ovf !== 1'b1) begin
            failures++;
            $display("FAIL sub_ovf got Z=%h ovf=%b want Z=7fffffffffffffff ovf=1", Z, ovf);
        end
        S0 = 2'b01; X = 64'd1; Y = 64'h8000_0000_0000_0000;
        #1;
        checks++;
        if (Z !== 64'h8000_0000_0000_0001 || ovf !== 1'b1) begin
            failures++;
            $display("FAIL sub_ovf_pos got Z=%h ovf=%b want Z=8000000000000001 ovf=1", Z, ovf);
        end
    endtask

    task automatic test_logic();
        @(negedge clk);
        S0 = 2'b10; X = 64'hF0F0; Y = 64'hFF00;
        #1;
        checks++;
        if (Z !== 64'h0FF0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL xor got Z=%h ovf=%b want Z=0ff0 ovf=0", Z, ovf);
        end
        S0 = 2'b11;
        #1;
        checks++;
        if (Z !== 64'hF000 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL and got Z=%h ovf=%b want Z=f000 ovf=0", Z, ovf);
        end
        S0 = 2'b10; X = 64'h7FFF_0000_1234_5678; Y = 64'h7FFF_0000_1234_5678;
        #1;
        checks++;
        if (Z !== 64'd0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL xor_self got Z=%h ovf=%b want Z=0 ovf=0", Z, ovf);
        end
        S0 = 2'b11; X = 64'h8000_0000_0000_0000; Y = 64'h8000_0000_0000_0000;
        #1;
        checks++;
        if (Z !== 64'h8000_0000_0000_0000 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL and_msb got Z=%h ovf=%b want Z=8000000000000000 ovf=0", Z, ovf);
        end
    endtask

    task automatic test_flags_load();
        @(negedge clk);
        S0 = 2'b01; X = 64'd42; Y = 64'd42; cc_en = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({zf, sf, of} !== 3'b100) begin
            failures++;
            $display("FAIL flags_zero got=%b want=100", {zf, sf, of});
        end
        @(negedge clk);
        cc_en = 1'b0; X = 64'd0; Y = 64'd1;
        @(posedge clk); #1;
        checks++;
        if ({zf, sf, of} !== 3'b100) begin
            failures++;
            $display("FAIL flags_hold got=%b want=100", {zf, sf, of});
        end
    endtask

    task automatic test_flags_sign();
        @(negedge clk);
        S0 = 2'b00; X = 64'h7FFF_FFFF_FFFF_FFFF; Y = 64'd1; cc_en = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({zf, sf, of} !== 3'b011) begin
            failures++;
            $display("FAIL flags_sign_ovf got=%b want=011", {zf, sf, of});
        end
        @(negedge clk);
        S0 = 2'b01; X = 64'd3; Y = 64'd10;
        @(posedge clk); #1;
        checks++;
        if ({zf, sf, of} !== 3'b010) begin
            failures++;
            $display("FAIL flags_neg got=%b want=010", {zf, sf, of});
        end
        @(negedge clk);
        cc_en = 1'b0;
    endtask

    task automatic test_async_reset();
        // Flags hold sf=1 from the previous test; reset mid-cycle, away from edges.
        @(negedge clk);
        S0 = 2'b00; X = 64'd5; Y = 64'd7;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({zf, sf, of} !== 3'b000) begin
            failures++;
            $display("FAIL async_reset_flags got=%b want=000", {zf, sf, of});
        end
        X = 64'd100; Y = 64'd23;
        #1;
        checks++;
        if (Z !== 64'd123) begin
            failures++;
            $display("FAIL z_during_reset got Z=%h want Z=%h", Z, 64'd123);
        end
        rst_n = 1'b1;
        S0 = 2'b00; X = 64'h7FFF_FFFF_FFFF_FFFF; Y = 64'd1; cc_en = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({zf, sf, of} !== 3'b011) begin
            failures++;
            $display("FAIL reload_after_reset got=%b want=011", {zf, sf, of});
        end
        cc_en = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n = 1'b1;
        cc_en = 1'b0;
        S0 = 2'b00;
        X  = 64'd0;
        Y  = 64'd0;
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_flags_load();
        test_flags_sign();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
